uart_word_receiver: RTL and testbench
=====================================

Name: uart_word_receiver

Overview:
- Receive side of the FPGA–PC UART link; pairs with the existing uart_transmit (8N1, LSB first).
- Takes the raw rx pin, synchronises it, recovers bytes by mid-bit sampling, and packs WORD_BYTES consecutive bytes into one wide word (e.g. a ciphertext chunk).
- Sits between the board pin and the SPI controller's data input.

Parameters:
INPUT_CLOCK_FREQ, 100_000_000, system clock in Hz
BAUD_RATE, 9600, line rate; BAUD_PERIOD = INPUT_CLOCK_FREQ/BAUD_RATE (integer division), HALF_PERIOD = BAUD_PERIOD/2
WORD_BYTES, 4, bytes per assembled word (>=1)
TIMEOUT_BITS, 20, idle bit-periods after which a partial word is discarded

Ports:
clk_in  input  1  system clock
rst_in  input  1  reset; asynchronous, active-high
rx_wire_in  input  1  raw UART line, asynchronous, idle high
byte_out  output  8  last good byte
byte_valid_out  output  1  one-cycle pulse per good byte
word_out  output  8*WORD_BYTES  last complete word; byte k at [8k+7:8k], first-received byte at k=0
word_valid_out  output  1  one-cycle pulse per complete word
frame_err_out  output  1  one-cycle pulse on bad stop bit
timeout_out  output  1  one-cycle pulse when a partial word is dropped

Behaviour:
- Reset (async): all outputs 0; FSM IDLE; byte index 0; both sync flops preset to 1 so reset never looks like a start bit.
- rx_wire_in passes through a 2-flop synchroniser; all logic uses the synced value (rx_s). Adds 2 cycles of latency.
- FSM states:
  - IDLE: on rx_s==0 → START; clear baud counter.
  - START: count HALF_PERIOD cycles, then sample. If rx_s==1, this was a false start (glitch) → IDLE with no pulse. Otherwise → DATA, bit count 0.
  - DATA: every BAUD_PERIOD cycles, sample into shift register LSB first. After the 8th sample → STOP.
  - STOP: after BAUD_PERIOD cycles, sample.
    - rx_s==1: byte_out<=shift, byte_valid_out pulses next cycle, → IDLE. Returning mid-stop-bit allows back-to-back frames.
    - rx_s==0: frame_err_out pulses; byte discarded; byte index reset to 0 (partial word dropped); → BREAK.
  - BREAK: wait for rx_s==1, then → IDLE. A held-low line produces exactly one frame_err pulse.
- Word assembly:
  - Good byte written at slot byte index, then index increments.
  - When index == WORD_BYTES-1 on a good byte: word_out updates, and word_valid_out pulses in the same cycle as byte_valid_out; index wraps to 0.
  - word_out holds its value between words.
  - WORD_BYTES==1: every byte is a word.
- Timeout: an idle counter runs only while in IDLE with index != 0, and clears on any start. On reaching TIMEOUT_BITS*BAUD_PERIOD cycles: index<=0, timeout_out pulses once. word_out is unchanged.
- Pulses are never asserted two cycles in a row; byte_valid_out and frame_err_out are mutually exclusive.
- Reset mid-frame: immediate return to IDLE, partial byte and word lost, no pulses.
- Counter widths: $clog2(BAUD_PERIOD+1) for the baud counter, $clog2(TIMEOUT_BITS*BAUD_PERIOD+1) for the idle counter, $clog2(WORD_BYTES) (min 1) for the byte index.

Decomposition:
- Shared package uart_pkg: rx state enum {IDLE, START, DATA, STOP, BREAK}, a baud_period(freq, baud) function, and a UART_DATA_BITS=8 constant. uart_transmit may reuse it later.
- One sub-module, uart_byte_rx: synchroniser plus bit-level FSM, with outputs byte/valid/frame_err.
- Top module: word packer and timeout logic.

Test Plan (sim params INPUT_CLOCK_FREQ=1_000_000, BAUD_RATE=100_000 → BAUD_PERIOD=10; WORD_BYTES=4; TIMEOUT_BITS=20):
- Send bytes 0xEF, 0xBE, 0xAD, 0xDE back-to-back, one stop bit each → four byte_valid pulses; on the 4th, word_out=32'hDEADBEEF with word_valid_out high in the same cycle.
- Low glitch of 3 cycles on an idle line → no pulses; FSM back in IDLE; next valid 0x55 is received correctly.
- Frame 0xA5 with stop bit held low for 30 cycles → exactly one frame_err_out pulse, no byte_valid; following 4 good bytes 0x01..0x04 → word_out=32'h04030201.
- Send 0x11, 0x22, then idle 200 cycles → timeout_out pulses once; word_out unchanged. Then 4 bytes 0x0A..0x0D → word_out=32'h0D0C0B0A.
- Assert rst_in mid-DATA of the 2nd byte → all outputs 0 immediately; the next 4 bytes form a full word from index 0.
- Sweep BAUD_RATE=9600 at 100 MHz with tx clock skewed ±2% → 0xC3 is received correctly at both extremes.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state type, data width and baud helper for the rx/tx pair
package uart_pkg;
  localparam int UART_DATA_BITS = 8;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_e;
  function automatic int baud_period(input int freq, input int baud);
    return freq / baud;
  endfunction
endpackage

// File: rtl/uart_byte_rx.sv
// uart_byte_rx: rx pin synchroniser and 8N1 mid-bit sampling byte receiver
module uart_byte_rx import uart_pkg::*; #(
  parameter int BAUD_PERIOD = 10416
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      rx_i,
  output logic [UART_DATA_BITS-1:0] byte_o,
  output logic                      valid_o,
  output logic                      frame_err_o,
  output logic                      idle_o
);
  localparam int HALF_PERIOD = BAUD_PERIOD / 2;
  localparam int CW = $clog2(BAUD_PERIOD + 1);
  localparam int BW = $clog2(UART_DATA_BITS);
  rx_state_e state_q, state_d;
  logic [1:0] sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic rx_s, half_done, baud_done;
  assign rx_s = sync_q[1];
  assign half_done = cnt_q == CW'(HALF_PERIOD - 1);
  assign baud_done = cnt_q == CW'(BAUD_PERIOD - 1);
  assign byte_o = shift_q;
  assign idle_o = state_q == IDLE;
  // sync flops preset high so reset release never looks like a start bit
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q  <= 2'b11;
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      sync_q  <= {sync_q[0], rx_i};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q + 1'b1;
    bit_d = bit_q;
    shift_d = shift_q;
    valid_o = 1'b0;
    frame_err_o = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = START;
      end
      START: if (half_done) begin
        cnt_d = '0;
        bit_d = '0;
        state_d = rx_s ? IDLE : DATA;
      end
      DATA: if (baud_done) begin
        cnt_d = '0;
        shift_d = {rx_s, shift_q[UART_DATA_BITS-1:1]};
        bit_d = bit_q + 1'b1;
        if (bit_q == BW'(UART_DATA_BITS - 1)) state_d = STOP;
      end
      STOP: if (baud_done) begin
        cnt_d = '0;
        valid_o = rx_s;
        frame_err_o = !rx_s;
        state_d = rx_s ? IDLE : BREAK;
      end
      BREAK: begin
        cnt_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: rtl/uart_word_receiver.sv
// uart_word_receiver: packs received UART bytes into WORD_BYTES-wide words,
// dropping a partial word after TIMEOUT_BITS idle bit periods or a framing error
module uart_word_receiver import uart_pkg::*; #(
  parameter int INPUT_CLOCK_FREQ = 100_000_000,
  parameter int BAUD_RATE        = 9600,
  parameter int WORD_BYTES       = 4,
  parameter int TIMEOUT_BITS     = 20
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    rx_wire_in,
  output logic [7:0]              byte_out,
  output logic                    byte_valid_out,
  output logic [8*WORD_BYTES-1:0] word_out,
  output logic                    word_valid_out,
  output logic                    frame_err_out,
  output logic                    timeout_out
);
  localparam int BP = baud_period(INPUT_CLOCK_FREQ, BAUD_RATE);
  localparam int LIMIT = TIMEOUT_BITS * BP;
  localparam int IW = WORD_BYTES > 1 ? $clog2(WORD_BYTES) : 1;
  localparam int TW = $clog2(LIMIT + 1);
  localparam int WW = 8 * WORD_BYTES;
  logic good, err, idle, last, run, hit;
  logic [7:0] rx_byte, byte_q, byte_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [WW-1:0] buf_q, buf_d, word_q, word_d;
  logic bv_q, wv_q, fe_q, to_q;
  uart_byte_rx #(.BAUD_PERIOD(BP)) u_rx (
    .clk_i      (clk_in),
    .rst_i      (rst_in),
    .rx_i       (rx_wire_in),
    .byte_o     (rx_byte),
    .valid_o    (good),
    .frame_err_o(err),
    .idle_o     (idle)
  );
  always_comb begin
    last = idx_q == IW'(WORD_BYTES - 1);
    run = idle && idx_q != '0;
    hit = run && tmo_q == TW'(LIMIT - 1);
    buf_d = buf_q;
    for (int k = 0; k < WORD_BYTES; k++)
      if (good && idx_q == IW'(k)) buf_d[k*8 +: 8] = rx_byte;
    word_d = good && last ? buf_d : word_q;
    byte_d = good ? rx_byte : byte_q;
    idx_d = err || hit || (good && last) ? '0 : good ? idx_q + 1'b1 : idx_q;
    tmo_d = run && !hit ? tmo_q + 1'b1 : '0;
  end
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      byte_q <= '0;
      idx_q  <= '0;
      tmo_q  <= '0;
      buf_q  <= '0;
      word_q <= '0;
      bv_q   <= 1'b0;
      wv_q   <= 1'b0;
      fe_q   <= 1'b0;
      to_q   <= 1'b0;
    end else begin
      byte_q <= byte_d;
      idx_q  <= idx_d;
      tmo_q  <= tmo_d;
      buf_q  <= buf_d;
      word_q <= word_d;
      bv_q   <= good;
      wv_q   <= good && last;
      fe_q   <= err;
      to_q   <= hit;
    end
  end
  assign byte_out = byte_q;
  assign byte_valid_out = bv_q;
  assign word_out = word_q;
  assign word_valid_out = wv_q;
  assign frame_err_out = fe_q;
  assign timeout_out = to_q;
endmodule

// File: tb/tb_uart_word_receiver.sv
// tb_uart_word_receiver: directed scenarios with byte/word scoreboards for uart_word_receiver
module tb_uart_word_receiver;
  logic clk = 1'b0, rst = 1'b1, rxa = 1'b1, rxb = 1'b1;
  logic [7:0] a_byte, b_byte;
  logic [31:0] a_word, b_word;
  logic a_bv, a_wv, a_fe, a_to, b_bv, b_wv, b_fe, b_to;
  int total = 0, bad = 0, err_cnt = 0, to_cnt = 0;
  logic [7:0] qa[$], qb[$];
  logic [31:0] qw[$];
  logic prev_bv = 1'b0, prev_fe = 1'b0, prev_to = 1'b0;
  logic [8:0] eb, ebb;
  logic [32:0] ew;
  logic [7:0] s1[4] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
  always #5 clk = ~clk;

  uart_word_receiver #(.INPUT_CLOCK_FREQ(1_000_000), .BAUD_RATE(100_000),
                       .WORD_BYTES(4), .TIMEOUT_BITS(20)) dut_a (
    .clk_in(clk), .rst_in(rst), .rx_wire_in(rxa), .byte_out(a_byte),
    .byte_valid_out(a_bv), .word_out(a_word), .word_valid_out(a_wv),
    .frame_err_out(a_fe), .timeout_out(a_to));

  // 1 MHz / 9600 keeps the +-2% skew sweep short while keeping a ~104-cycle bit
  uart_word_receiver #(.INPUT_CLOCK_FREQ(1_000_000), .BAUD_RATE(9600),
                       .WORD_BYTES(4), .TIMEOUT_BITS(20)) dut_b (
    .clk_in(clk), .rst_in(rst), .rx_wire_in(rxb), .byte_out(b_byte),
    .byte_valid_out(b_bv), .word_out(b_word), .word_valid_out(b_wv),
    .frame_err_out(b_fe), .timeout_out(b_to));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic v, input int n);
    if (sel) rxb = v; else rxa = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input bit sel, input logic [7:0] b, input int bc);
    drive(sel, 1'b0, bc);
    for (int i = 0; i < 8; i++) drive(sel, b[i], bc);
    drive(sel, 1'b1, bc);
  endtask

  always @(negedge clk) begin
    if (a_bv) begin
      eb = 9'h100;
      if (qa.size() > 0) eb = {1'b0, qa.pop_front()};
      chk("byte", {1'b0, a_byte}, eb);
      chk("byte_twice", prev_bv, 0);
    end
    if (a_wv) begin
      ew = 33'h1_0000_0000;
      if (qw.size() > 0) ew = {1'b0, qw.pop_front()};
      chk("word", {1'b0, a_word}, ew);
      chk("word_without_byte", a_bv, 1);
    end
    if (a_fe) begin
      err_cnt++;
      chk("err_with_byte", a_bv, 0);
      chk("err_twice", prev_fe, 0);
    end
    if (a_to) begin
      to_cnt++;
      chk("timeout_twice", prev_to, 0);
    end
    prev_bv = a_bv;
    prev_fe = a_fe;
    prev_to = a_to;
    if (b_bv) begin
      ebb = 9'h100;
      if (qb.size() > 0) ebb = {1'b0, qb.pop_front()};
      chk("b_byte", {1'b0, b_byte}, ebb);
    end
    if (b_fe) chk("b_frame_err", b_fe, 0);
    if (b_wv) chk("b_word_valid", b_wv, 0);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_byte", a_byte, 0);
    chk("rst_bv", a_bv, 0);
    chk("rst_word", a_word, 0);
    chk("rst_wv", a_wv, 0);
    chk("rst_fe", a_fe, 0);
    chk("rst_to", a_to, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    qw.push_back(32'hDEADBEEF);
    for (int i = 0; i < 4; i++) begin
      qa.push_back(s1[i]);
      send_byte(0, s1[i], 10);
    end
    drive(0, 1'b1, 30);
    chk("pending_1", qa.size() + qw.size(), 0);
    chk("word_1", a_word, 32'hDEADBEEF);

    drive(0, 1'b0, 3);
    drive(0, 1'b1, 30);
    chk("glitch_err", err_cnt, 0);
    chk("glitch_byte", a_byte, 8'hDE);
    qa.push_back(8'h55);
    send_byte(0, 8'h55, 10);
    drive(0, 1'b1, 30);
    chk("pending_2", qa.size(), 0);

    drive(0, 1'b0, 10);
    for (int i = 0; i < 8; i++) drive(0, 8'hA5 >> i, 10);
    drive(0, 1'b0, 30);
    drive(0, 1'b1, 30);
    chk("frame_err_count", err_cnt, 1);
    chk("frame_err_byte", a_byte, 8'h55);
    qw.push_back(32'h04030201);
    for (int i = 1; i <= 4; i++) begin
      qa.push_back(8'(i));
      send_byte(0, 8'(i), 10);
    end
    drive(0, 1'b1, 30);
    chk("pending_3", qa.size() + qw.size(), 0);
    chk("word_3", a_word, 32'h04030201);

    qa.push_back(8'h11);
    send_byte(0, 8'h11, 10);
    qa.push_back(8'h22);
    send_byte(0, 8'h22, 10);
    drive(0, 1'b1, 250);
    chk("timeout_count", to_cnt, 1);
    chk("word_hold", a_word, 32'h04030201);
    qw.push_back(32'h0D0C0B0A);
    for (int i = 10; i <= 13; i++) begin
      qa.push_back(8'(i));
      send_byte(0, 8'(i), 10);
    end
    drive(0, 1'b1, 30);
    chk("pending_4", qa.size() + qw.size(), 0);
    chk("word_4", a_word, 32'h0D0C0B0A);
    chk("timeout_count_final", to_cnt, 1);

    qa.push_back(8'h77);
    send_byte(0, 8'h77, 10);
    drive(0, 1'b0, 10);
    for (int i = 0; i < 3; i++) drive(0, 1'b0, 10);
    rst = 1'b1;
    #1;
    chk("mid_rst_byte", a_byte, 0);
    chk("mid_rst_word", a_word, 0);
    chk("mid_rst_bv", a_bv | a_wv | a_fe | a_to, 0);
    rxa = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    drive(0, 1'b1, 20);
    qw.push_back(32'h34333231);
    for (int i = 8'h31; i <= 8'h34; i++) begin
      qa.push_back(8'(i));
      send_byte(0, 8'(i), 10);
    end
    drive(0, 1'b1, 30);
    chk("pending_5", qa.size() + qw.size(), 0);
    chk("word_5", a_word, 32'h34333231);

    qb.push_back(8'hC3);
    send_byte(1, 8'hC3, 106);
    drive(1, 1'b1, 60);
    chk("skew_slow", qb.size(), 0);
    qb.push_back(8'hC3);
    send_byte(1, 8'hC3, 102);
    drive(1, 1'b1, 60);
    chk("skew_fast", qb.size(), 0);
    chk("skew_byte", b_byte, 8'hC3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
